// File: rtl/euler_step_scheduler_if.sv
// euler_step_scheduler_if: go/parameter inputs, core handshake and status bundle for the Euler step scheduler
// master: run requester plus Euler core (drives go, num_steps, h_step, t0, core_finish, core_error)
// slave:  scheduler (drives core_start, core_h_step, buf_sel, t_cur, step_cnt, busy, done, err_code)
interface euler_step_scheduler_if #(
  parameter int DATA_SIZE = 16,
  parameter int STEP_W = 16
);
  logic go;
  logic [STEP_W-1:0] num_steps;
  logic [DATA_SIZE-1:0] h_step;
  logic [DATA_SIZE-1:0] t0;
  logic core_start;
  logic core_finish;
  logic core_error;
  logic [DATA_SIZE-1:0] core_h_step;
  logic buf_sel;
  logic [DATA_SIZE-1:0] t_cur;
  logic [STEP_W-1:0] step_cnt;
  logic busy;
  logic done;
  logic [1:0] err_code;
  modport master (
    output go, num_steps, h_step, t0, core_finish, core_error,
    input core_start, core_h_step, buf_sel, t_cur, step_cnt, busy, done, err_code
  );
  modport slave (
    input go, num_steps, h_step, t0, core_finish, core_error,
    output core_start, core_h_step, buf_sel, t_cur, step_cnt, busy, done, err_code
  );
endinterface

// File: rtl/euler_step_scheduler.sv
// euler_step_scheduler: sequences num_steps Euler core runs, advancing time and flipping the ping-pong bank
// clk: rising-edge clock; rst: asynchronous active-low reset; bus: euler_step_scheduler_if.slave
// Optional macro EULER_SCHED_WATCHDOG_EN adds a WAIT-cycle watchdog (err_code 11 after WDOG_LIMIT cycles).
module euler_step_scheduler #(
  parameter int DATA_SIZE = 16,
  parameter int STEP_W = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input logic clk,
  input logic rst,
  euler_step_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ADVANCE, DONE} state_t;
  state_t state_q;
  logic [STEP_W-1:0] nsteps_q, cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] h_q, t_q;
  logic [DATA_SIZE:0] sum_d;
  logic buf_q, start_q, busy_q, done_q, blank_q, wd_hit;
  logic [1:0] err_q;
  if (WDOG_LIMIT < 1) begin : g_bad_limit
    $error("WDOG_LIMIT must be at least 1");
  end
  assign sum_d = {1'b0, t_q} + {1'b0, h_q};
  assign cnt_d = cnt_q + 1'b1;
`ifdef EULER_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] wd_q;
  assign wd_hit = wd_q == WD_W'(WDOG_LIMIT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) wd_q <= '0;
    else if (state_q == LAUNCH) wd_q <= '0;
    else if (state_q == WAIT) wd_q <= wd_q + 1'b1;
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      nsteps_q <= '0;
      cnt_q <= '0;
      h_q <= '0;
      t_q <= '0;
      buf_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      blank_q <= 1'b0;
      err_q <= 2'b00;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (bus.go) begin
          nsteps_q <= bus.num_steps;
          h_q <= bus.h_step;
          t_q <= bus.t0;
          cnt_q <= '0;
          buf_q <= 1'b0;
          err_q <= 2'b00;
          if (bus.num_steps == '0) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end else begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
          blank_q <= 1'b1;
        end
        WAIT: begin
          // first WAIT cycle may still see the previous step's finish level
          blank_q <= 1'b0;
          if (!blank_q && bus.core_finish) begin
            if (bus.core_error) begin
              err_q <= 2'b01;
              state_q <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else state_q <= ADVANCE;
          end else if (wd_hit) begin
            err_q <= 2'b11;
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ADVANCE: begin
          t_q <= sum_d[DATA_SIZE-1:0];
          cnt_q <= cnt_d;
          buf_q <= ~buf_q;
          if (sum_d[DATA_SIZE] || cnt_d == nsteps_q) begin
            err_q <= sum_d[DATA_SIZE] ? 2'b10 : 2'b00;
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.core_start = start_q;
  assign bus.core_h_step = h_q;
  assign bus.buf_sel = buf_q;
  assign bus.t_cur = t_q;
  assign bus.step_cnt = cnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err_code = err_q;
endmodule

// File: doc/euler_step_scheduler.md
EULER_STEP_SCHEDULER -- requirements
Module: euler_step_scheduler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, width of h_step, t0 and t_cur.
REQ-002 SHALL have parameter STEP_W, default 16, width of num_steps and step_cnt.
REQ-003 SHALL have parameter WDOG_LIMIT, default 1024, the maximum number of WAIT cycles per step.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port go  in  1  run request, sampled only in IDLE or DONE.
REQ-007 SHALL have port num_steps  in  STEP_W  number of Euler steps to run, latched on go.
REQ-008 SHALL have port h_step  in  DATA_SIZE  step size, latched on go.
REQ-009 SHALL have port t0  in  DATA_SIZE  initial time, latched on go.
REQ-010 SHALL have port core_start  out  1  one-cycle start pulse to the Euler core.
REQ-011 SHALL have port core_finish  in  1  core finish level, held high until the next core_start.
REQ-012 SHALL have port core_error  in  1  core error level, valid while core_finish=1.
REQ-013 SHALL have port core_h_step  out  DATA_SIZE  latched step size driven to the core.
REQ-014 SHALL have port buf_sel  out  1  ping-pong state-vector bank select; core reads bank buf_sel and writes bank ~buf_sel.
REQ-015 SHALL have port t_cur  out  DATA_SIZE  current simulation time.
REQ-016 SHALL have port step_cnt  out  STEP_W  number of completed steps.
REQ-017 SHALL have port busy  out  1  high in LAUNCH, WAIT and ADVANCE.
REQ-018 SHALL have port done  out  1  high in DONE.
REQ-019 SHALL have port err_code  out  2  error cause: 00 none, 01 core error, 10 time overflow, 11 watchdog.

Function
REQ-020 SHALL implement the states IDLE, LAUNCH, WAIT, ADVANCE and DONE.
REQ-021 In IDLE or DONE, go=1 SHALL latch num_steps, h_step and t0, set t_cur=t0, clear step_cnt, buf_sel and err_code, and go to LAUNCH; if num_steps=0 it SHALL go to DONE instead, with no core_start.
REQ-022 go SHALL be ignored while busy=1.
REQ-023 LAUNCH SHALL last exactly one cycle with core_start=1 and SHALL then go to WAIT.
REQ-024 The first WAIT cycle SHALL ignore core_finish (blanking for the stale finish clearing in the core).
REQ-025 From the second WAIT cycle, core_finish=1 with core_error=0 SHALL move to ADVANCE.
REQ-026 core_finish=1 with core_error=1 SHALL set err_code=01 and go to DONE.
REQ-027 ADVANCE SHALL last one cycle and SHALL set t_cur <= t_cur + h_step (unsigned, DATA_SIZE bits), step_cnt <= step_cnt+1 and buf_sel <= ~buf_sel.
REQ-028 If the t_cur addition carries out, ADVANCE SHALL keep the wrapped t_cur, set err_code=10 and go to DONE.
REQ-029 Otherwise, after ADVANCE the block SHALL go to DONE if the new step_cnt equals num_steps, else to LAUNCH.
REQ-030 The latency from core_finish to the next core_start SHALL be 2 cycles (ADVANCE, then LAUNCH).
REQ-031 In DONE, t_cur, step_cnt, buf_sel and err_code SHALL hold until the next accepted go.
REQ-032 core_start SHALL never be asserted outside LAUNCH.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE with core_start=0, busy=0, done=0, err_code=00, step_cnt=0, t_cur=0, buf_sel=0 and core_h_step=0.
REQ-034 Reset during any state, including mid-step, SHALL abandon the run; no core_start SHALL be issued until a new go is accepted after reset release.
REQ-035 The watchdog counter SHALL be cleared by reset.

Configuration
REQ-036 With macro EULER_SCHED_WATCHDOG_EN defined, a counter SHALL count WAIT cycles; reaching WDOG_LIMIT without core_finish SHALL set err_code=11 and go to DONE; the counter SHALL clear on entry to WAIT.
REQ-037 Without EULER_SCHED_WATCHDOG_EN, no counter SHALL exist, WAIT SHALL wait indefinitely, and err_code=11 SHALL never occur.

Verification
REQ-038 go with num_steps=3, t0=0x0000, h_step=0x0010, core finishing 5 cycles after each start -> 3 core_start pulses, t_cur=0x0030, step_cnt=3, buf_sel=1, done=1, err_code=00.
REQ-039 go with num_steps=0 -> DONE next cycle, no core_start, t_cur=t0.
REQ-040 num_steps=4, core_error=1 on step 2 -> err_code=01, step_cnt=1, done=1, only 2 core_start pulses.
REQ-041 t0=0xFFF0, h_step=0x0020, num_steps=2 -> err_code=10 after the first ADVANCE, t_cur=0x0010, step_cnt=1.
REQ-042 rst=0 asserted in WAIT of step 2, released, core_finish still high -> block stays in IDLE with no core_start until go.
REQ-043 With EULER_SCHED_WATCHDOG_EN defined and WDOG_LIMIT=8, core never finishes -> err_code=11 exactly 8 WAIT cycles after LAUNCH, then DONE.
